// File: rtl/i2c_reg_master_pkg.sv
// Shared types and defaults for the IMU-bus I2C register master.
package i2c_reg_master_pkg;
    typedef enum logic [2:0] {
        IDLE, START, BYTE, ACK, RSTART, RBYTE, MNACK, STOP
    } i2c_state_e;

    localparam logic [6:0] I2C_DEV_ADDR_MPU = 7'h68;
    localparam int         I2C_CLK_DIV_DEF  = 32;
endpackage

// File: rtl/i2c_reg_master_if.sv
// Request/handshake and pad signals of the I2C register master.
interface i2c_reg_master_if;
    logic [7:0] I2C_ADDR;
    logic [7:0] I2C_WRITE_DATA;
    logic       I2C_WRITE_EN;
    logic       I2C_READ_EN;
    logic [7:0] I2C_READ_DATA;
    logic       SDA_IN;
    logic       SCL_OUT;
    logic       SDA_OUT;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;

    modport master (
        input  I2C_ADDR, I2C_WRITE_DATA, I2C_WRITE_EN, I2C_READ_EN, SDA_IN,
        output SCL_OUT, SDA_OUT, BUSY, DONE, ERROR, I2C_READ_DATA
    );
    modport slave (
        output I2C_ADDR, I2C_WRITE_DATA, I2C_WRITE_EN, I2C_READ_EN, SDA_IN,
        input  SCL_OUT, SDA_OUT, BUSY, DONE, ERROR, I2C_READ_DATA
    );
endinterface

// File: rtl/i2c_bit_timer.sv
// Quarter-bit timer: CLK_DIV cycles per phase, four phases per bit, idle at 0.
module i2c_bit_timer
    import i2c_reg_master_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       run,
    output logic [1:0] phase,
    output logic       last
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [QW-1:0] qcnt;

    assign last = run && (qcnt == QW'(CLK_DIV - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            qcnt  <= '0;
            phase <= 2'd0;
        end else if (!run) begin
            qcnt  <= '0;
            phase <= 2'd0;
        end else if (last) begin
            qcnt  <= '0;
            phase <= phase + 2'd1;
        end else begin
            qcnt  <= qcnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_reg_master.sv
// Single-register I2C write master: START, {DEV_ADDR,W}, reg addr, data, STOP.
// Define I2C_READ_EN to add a register read (repeated START, one byte, NACK).
module i2c_reg_master
    import i2c_reg_master_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR_MPU,
    parameter int         CLK_DIV  = I2C_CLK_DIV_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    i2c_reg_master_if.master bus
);
    i2c_state_e state;
    logic [1:0] phase, idx;
    logic       last, bit_end, ph1_end;
    logic       we_q, we_rise, nack;
    logic       busy, done, error, scl, sda, scl_n, sda_n;
    logic [7:0] addr_q, data_q, shreg;
    logic [2:0] bitcnt;
`ifdef I2C_READ_EN
    logic       re_q, re_rise, rd;
    logic [7:0] rx, rdata;
    assign re_rise           = bus.I2C_READ_EN & ~re_q;
    assign bus.I2C_READ_DATA = rdata;
`else
    logic       re_rise, unused_read_en;
    assign re_rise           = 1'b0;
    assign unused_read_en    = bus.I2C_READ_EN;
    assign bus.I2C_READ_DATA = 8'h00;
`endif

    i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .CLK(CLK), .RST(RST), .run(busy), .phase(phase), .last(last)
    );

    assign we_rise     = bus.I2C_WRITE_EN & ~we_q;
    assign bit_end     = last && (phase == 2'd3);
    assign ph1_end     = last && (phase == 2'd1);
    assign bus.SCL_OUT = scl;
    assign bus.SDA_OUT = sda;
    assign bus.BUSY    = busy;
    assign bus.DONE    = done;
    assign bus.ERROR   = error;

    // Line levels for the current state/phase; registered below, so both pads lag equally.
    always_comb begin
        scl_n = 1'b1;
        sda_n = 1'b1;
        case (state)
            START:      begin scl_n = (phase != 2'd3);   sda_n = (phase < 2'd2);  end
            BYTE:       begin scl_n = phase[0] ^ phase[1]; sda_n = shreg[7];      end
            ACK:        scl_n = phase[0] ^ phase[1];
            STOP:       begin scl_n = (phase != 2'd0);   sda_n = (phase == 2'd3); end
`ifdef I2C_READ_EN
            RSTART:     begin scl_n = phase[0] ^ phase[1]; sda_n = (phase < 2'd2); end
            RBYTE,
            MNACK:      scl_n = phase[0] ^ phase[1];
`endif
            default:    ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            we_q   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            scl    <= 1'b1;
            sda    <= 1'b1;
            nack   <= 1'b0;
            addr_q <= 8'h00;
            data_q <= 8'h00;
            shreg  <= 8'h00;
            bitcnt <= 3'd0;
            idx    <= 2'd0;
`ifdef I2C_READ_EN
            re_q   <= 1'b0;
            rd     <= 1'b0;
            rx     <= 8'h00;
            rdata  <= 8'h00;
`endif
        end else begin
            we_q <= bus.I2C_WRITE_EN;
`ifdef I2C_READ_EN
            re_q <= bus.I2C_READ_EN;
`endif
            scl  <= scl_n;
            sda  <= sda_n;
            done <= 1'b0;
            case (state)
                IDLE: if (we_rise || re_rise) begin
                    addr_q <= bus.I2C_ADDR;
                    data_q <= bus.I2C_WRITE_DATA;
                    error  <= 1'b0;
                    busy   <= 1'b1;
                    state  <= START;
`ifdef I2C_READ_EN
                    rd     <= ~we_rise;
`endif
                end
                START: if (bit_end) begin
                    shreg  <= {DEV_ADDR, 1'b0};
                    bitcnt <= 3'd7;
                    idx    <= 2'd0;
                    state  <= BYTE;
                end
                BYTE: if (bit_end) begin
                    shreg <= {shreg[6:0], 1'b0};
                    if (bitcnt == 3'd0) state <= ACK;
                    else                bitcnt <= bitcnt - 3'd1;
                end
                ACK: begin
                    if (ph1_end) nack <= bus.SDA_IN;
                    if (bit_end) begin
                        bitcnt <= 3'd7;
                        if (nack) begin
                            error <= 1'b1;
                            state <= STOP;
                        end else begin
                            case (idx)
                                2'd0: begin shreg <= addr_q; idx <= 2'd1; state <= BYTE; end
                                2'd1: begin
                                    idx <= 2'd2;
`ifdef I2C_READ_EN
                                    if (rd) state <= RSTART;
                                    else
`endif
                                    begin shreg <= data_q; state <= BYTE; end
                                end
                                default: begin
`ifdef I2C_READ_EN
                                    if (rd) state <= RBYTE;
                                    else
`endif
                                    state <= STOP;
                                end
                            endcase
                        end
                    end
                end
`ifdef I2C_READ_EN
                RSTART: if (bit_end) begin
                    shreg  <= {DEV_ADDR, 1'b1};
                    bitcnt <= 3'd7;
                    state  <= BYTE;
                end
                RBYTE: begin
                    if (ph1_end) rx <= {rx[6:0], bus.SDA_IN};
                    if (bit_end) begin
                        if (bitcnt == 3'd0) state <= MNACK;
                        else                bitcnt <= bitcnt - 3'd1;
                    end
                end
                MNACK: if (bit_end) state <= STOP;
`endif
                STOP: if (bit_end) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef I2C_READ_EN
                    if (rd && !error) rdata <= rx;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: bus-level slave/decoder plus a byte-sequence reference model.
`timescale 1ns/1ps
module tb_i2c_reg_master;
    import i2c_reg_master_pkg::*;

    localparam int         CD  = 4;
    localparam logic [6:0] DEV = 7'h68;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    i2c_reg_master_if bus();
    i2c_reg_master #(.DEV_ADDR(DEV), .CLK_DIV(CD)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct packed {
        logic [63:0] bytes;
        logic [7:0]  acks;
        logic [7:0]  nb;
        logic [7:0]  ns;
    } frame_t;

    logic   sl_drv_n = 1'b1;
    logic   sda_line;
    assign sda_line   = bus.SDA_OUT & sl_drv_n;
    assign bus.SDA_IN = sda_line;

    frame_t     frames[$];
    frame_t     cur;
    logic       in_frame, p_scl, p_sda, tx;
    logic [7:0] sh, tx_byte;
    int         bitpos;
    int         nack_idx = -1;
    logic [7:0] rd_val   = 8'h00;
    bit         also_rd  = 1'b0;
    int         total = 0, bad = 0;

    // Bus decoder + slave: frames are START..STOP, each byte recorded with its ack bit.
    always @(negedge CLK) begin
        logic s, d;
        s = bus.SCL_OUT;
        d = sda_line;
        if (RST) begin
            in_frame = 1'b0; p_scl = 1'b1; p_sda = 1'b1;
            bitpos = 0; tx = 1'b0; sl_drv_n = 1'b1;
        end else begin
            if (p_scl && s && p_sda && !d) begin
                if (!in_frame) begin cur = '0; in_frame = 1'b1; end
                cur.ns++;
                bitpos = 0; tx = 1'b0; sl_drv_n = 1'b1;
            end else if (p_scl && s && !p_sda && d) begin
                if (in_frame) frames.push_back(cur);
                in_frame = 1'b0; tx = 1'b0; sl_drv_n = 1'b1;
            end else if (in_frame && !p_scl && s) begin
                if (bitpos < 8) sh = {sh[6:0], d};
                else if (cur.nb < 8) begin
                    cur.bytes[8*cur.nb +: 8] = sh;
                    cur.acks[cur.nb] = d;
                    cur.nb++;
                end
                bitpos = (bitpos + 1) % 9;
            end else if (in_frame && p_scl && !s) begin
                if (bitpos == 8) begin
                    sl_drv_n = tx || (int'(cur.nb) == nack_idx);
                    tx = 1'b0;
                end else if (bitpos == 0) begin
                    if (cur.nb > 0 && cur.bytes[8*(cur.nb-1) +: 8] == {DEV, 1'b1} &&
                        !cur.acks[cur.nb-1]) begin
                        tx = 1'b1; tx_byte = rd_val; sl_drv_n = rd_val[7];
                    end else sl_drv_n = 1'b1;
                end else if (tx) sl_drv_n = tx_byte[7-bitpos];
            end
            p_scl = s;
            p_sda = d;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // What should appear on the wire: the intended byte list, cut after the NACKed byte.
    function automatic frame_t model(input logic [7:0] a, input logic [7:0] d, input bit rd,
                                     input int nk, input logic [7:0] rv);
        frame_t     f;
        logic [7:0] q[$];
        f = '0;
        q.push_back({DEV, 1'b0});
        q.push_back(a);
        if (rd) begin q.push_back({DEV, 1'b1}); q.push_back(rv); end
        else    q.push_back(d);
        f.ns = (rd && (nk < 0 || nk > 1)) ? 8'd2 : 8'd1;
        for (int i = 0; i < q.size(); i++) begin
            f.bytes[8*i +: 8] = q[i];
            f.acks[i] = (rd && i == 3) || (i == nk);
            f.nb = 8'(i + 1);
            if (i == nk) break;
        end
        return f;
    endfunction

    task automatic chk_frame(input string tag, input frame_t e);
        frame_t f;
        chk({tag, "_nfrm"}, frames.size(), 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            chk({tag, "_nb"},    f.nb,    e.nb);
            chk({tag, "_ns"},    f.ns,    e.ns);
            chk({tag, "_bytes"}, f.bytes, e.bytes);
            chk({tag, "_acks"},  f.acks,  e.acks);
        end
        frames.delete();
    endtask

    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] d,
                           input bit rd, input int nk, input logic [7:0] rv, input int poke);
        int n;
        bit exp_err;
        exp_err  = (nk >= 0);
        nack_idx = nk;
        rd_val   = rv;
        @(negedge CLK);
        bus.I2C_ADDR       = a;
        bus.I2C_WRITE_DATA = d;
        if (rd) bus.I2C_READ_EN = 1'b1;
        else    bus.I2C_WRITE_EN = 1'b1;
        if (also_rd) bus.I2C_READ_EN = 1'b1;
        n = 0;
        while (bus.BUSY !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
        chk({tag, "_busy"}, bus.BUSY, 1);
        chk({tag, "_errclr"}, bus.ERROR, 0);
        bus.I2C_WRITE_EN = 1'b0;
        bus.I2C_READ_EN  = 1'b0;
        n = 0;
        while (bus.DONE !== 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
            if (n == poke) begin bus.I2C_WRITE_EN = 1'b1; bus.I2C_ADDR = ~a; end
        end
        chk({tag, "_done"}, bus.DONE, 1);
        if (nk < 0) chk({tag, "_len"}, n, (rd ? 39 : 29) * 4 * CD);
        chk({tag, "_busy_at_done"}, bus.BUSY, 0);
        chk({tag, "_err"}, bus.ERROR, exp_err);
`ifdef I2C_READ_EN
        if (rd && !exp_err) chk({tag, "_rdata"}, bus.I2C_READ_DATA, rv);
`endif
        @(negedge CLK);
        chk({tag, "_pulse"}, bus.DONE, 0);
        repeat (20) @(negedge CLK);
        chk({tag, "_idle"}, bus.BUSY, 0);
        bus.I2C_WRITE_EN = 1'b0;
        chk_frame(tag, model(a, d, rd, nk, rv));
    endtask

    logic [7:0] seq_a[5] = '{8'd107, 8'd107, 8'd107, 8'd26, 8'd56};
    logic [7:0] seq_d[5] = '{8'd128, 8'd0,   8'd1,   8'd1,  8'd1};

    initial begin
        bus.I2C_ADDR = 8'h00; bus.I2C_WRITE_DATA = 8'h00;
        bus.I2C_WRITE_EN = 1'b0; bus.I2C_READ_EN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_scl",   bus.SCL_OUT, 1);
        chk("rst_sda",   bus.SDA_OUT, 1);
        chk("rst_busy",  bus.BUSY, 0);
        chk("rst_done",  bus.DONE, 0);
        chk("rst_err",   bus.ERROR, 0);
        chk("rst_rdata", bus.I2C_READ_DATA, 0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        run_txn("w0", 8'd107, 8'd128, 1'b0, -1, 8'h00, 0);

        run_txn("nack", 8'd107, 8'd55, 1'b0, 1, 8'h00, 0);
        repeat (30) @(negedge CLK);
        chk("err_sticky", bus.ERROR, 1);
        run_txn("clr", 8'd20, 8'd30, 1'b0, -1, 8'h00, 0);

        run_txn("ign2", 8'h3C, 8'hA5, 1'b0, -1, 8'h00, 100);

        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("seq%0d", i), seq_a[i], seq_d[i], 1'b0, -1, 8'h00, 0);
            repeat (22) @(negedge CLK);
        end

        // Reset while the data byte is on the wire
        @(negedge CLK);
        nack_idx = -1;
        bus.I2C_ADDR = 8'h11; bus.I2C_WRITE_DATA = 8'h22; bus.I2C_WRITE_EN = 1'b1;
        repeat (2) @(negedge CLK);
        bus.I2C_WRITE_EN = 1'b0;
        repeat (333) @(negedge CLK);
        chk("mid_busy", bus.BUSY, 1);
        RST = 1'b1;
        #1;
        chk("mid_rst_scl",  bus.SCL_OUT, 1);
        chk("mid_rst_sda",  bus.SDA_OUT, 1);
        chk("mid_rst_busy", bus.BUSY, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_rst_nofrm", frames.size(), 0);
        run_txn("post_rst", 8'h44, 8'h99, 1'b0, -1, 8'h00, 0);

        for (int i = 0; i < 4; i++) begin
            int nk;
            nk = int'($urandom_range(0, 4)) - 1;
            if (nk > 2) nk = -1;
            run_txn($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'b0, nk, 8'h00, 0);
        end

        also_rd = 1'b1;
        run_txn("wr_wins", 8'h5A, 8'hC3, 1'b0, -1, 8'h00, 0);
        also_rd = 1'b0;

`ifdef I2C_READ_EN
        run_txn("rd", 8'd117, 8'h00, 1'b1, -1, 8'h68, 0);
        run_txn("rd_rnd", 8'($urandom), 8'h00, 1'b1, -1, 8'($urandom), 0);
        run_txn("rd_nack", 8'd117, 8'h00, 1'b1, 0, 8'h12, 0);
`else
        @(negedge CLK);
        bus.I2C_READ_EN = 1'b1;
        repeat (50) @(negedge CLK);
        chk("rd_ign_busy",  bus.BUSY, 0);
        chk("rd_ign_frm",   frames.size(), 0);
        chk("rd_ign_rdata", bus.I2C_READ_DATA, 0);
        bus.I2C_READ_EN = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
